// File: rtl/vga_timing_engine.sv
// VGA raster timing engine.
// Divides the system clock down to the pixel rate, runs the h/v raster
// counters, and registers sync, blanking and colour so that they stay
// aligned with each other. Also provides a frame-locked blink flag.
//
// Ports
//   reloj_nexys    in   system clock
//   reset_interno  in   asynchronous, active-high reset
//   blink_en       in   enable for the blink generator
//   color_in       in   colour for the current pixel_x/pixel_y (same cycle)
//   pixel_tick     out  one-clock strobe every CLK_DIV clocks
//   pixel_x/y      out  current raster position (direct from counters)
//   video_on       out  current position is inside the active area
//   frame_start    out  pulse on the tick where the raster wraps to (0,0)
//   hsync/vsync    out  registered sync, one tick behind the counters
//   rgb_out        out  registered colour, aligned with hsync/vsync
//   blink          out  toggles every BLINK_FRAMES frames while enabled
module vga_timing_engine #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b0,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned COLOR_W      = 12,
    parameter logic [COLOR_W-1:0] RESET_COLOR = {COLOR_W{1'b1}},
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic               reloj_nexys,
    input  logic               reset_interno,
    input  logic               blink_en,
    input  logic [COLOR_W-1:0] color_in,
    output logic               pixel_tick,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               video_on,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               blink
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_q,   div_d;
    logic               tick_q,  tick_d;
    logic [CNT_W-1:0]   h_q,     h_d;
    logic [CNT_W-1:0]   v_q,     v_d;
    logic               fs_q,    fs_d;
    logic               hs_q,    hs_d;
    logic               vs_q,    vs_d;
    logic [COLOR_W-1:0] rgb_q,   rgb_d;
    logic [FRM_W-1:0]   fcnt_q,  fcnt_d;
    logic               blink_q, blink_d;
    logic               vis_c;

    assign vis_c = (h_q < H_VIS) && (v_q < V_VIS);

    // Next-state logic for divider, raster counters, output stage and blink.
    always_comb begin
        div_d   = div_q;
        tick_d  = 1'b0;
        h_d     = h_q;
        v_d     = v_q;
        fs_d    = 1'b0;
        hs_d    = hs_q;
        vs_d    = vs_q;
        rgb_d   = rgb_q;
        fcnt_d  = fcnt_q;
        blink_d = blink_q;

        // The strobe is registered, so it is high in the clock after div hits its last value.
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + DIV_W'(1);

        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
            hs_d  = ((h_q >= H_SS) && (h_q < H_SE)) ? HS_POL : ~HS_POL;
            vs_d  = ((v_q >= V_SS) && (v_q < V_SE)) ? VS_POL : ~VS_POL;
            rgb_d = vis_c ? color_in : '0;
        end

        // Look at the counter values that will be live during the next tick.
        fs_d = tick_d && (h_d == H_LAST) && (v_d == V_LAST);

        if (!blink_en) begin
            fcnt_d  = '0;
            blink_d = 1'b0;
        end else if (fs_q) begin
            if (fcnt_q == FRM_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FRM_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge reloj_nexys or posedge reset_interno) begin
        if (reset_interno) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            fs_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            rgb_q   <= RESET_COLOR;
            fcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fs_q    <= fs_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            rgb_q   <= rgb_d;
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
        end
    end

    assign pixel_tick  = tick_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign video_on    = vis_c;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign rgb_out     = rgb_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine on a reduced raster (15x10, 4 clocks per pixel,
// blink every 3 frames) so several whole frames fit in a short run.
module tb_vga_timing_engine;

    localparam int CLK_DIV = 4;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int BF = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk;
    logic        rst;
    logic        blink_en;
    logic [11:0] color_in;
    logic        pixel_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb_out;
    logic        blink;

    vga_timing_engine #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(10), .COLOR_W(12),
        .RESET_COLOR(12'hFFF), .BLINK_FRAMES(BF)
    ) dut (
        .reloj_nexys(clk), .reset_interno(rst), .blink_en(blink_en),
        .color_in(color_in), .pixel_tick(pixel_tick), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .video_on(video_on), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out), .blink(blink)
    );

    typedef struct {
        int          idx;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        bl;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_on;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the character/colour selector.
    function automatic logic [11:0] sel_color(input int x, input int y);
        if (x == 0 && y == 0) return 12'hABC;
        return 12'(((x % 64) * 64) + (y % 64));
    endfunction

    assign color_in = sel_color(int'(pixel_x), int'(pixel_y));

    // Expected DUT state during the n-th pixel tick after reset release
    // (blink_en held high throughout).
    function automatic exp_t model(input int n);
        exp_t e;
        int p, q, qx, qy;
        p      = n - 1;
        e.idx  = n;
        e.x    = 10'(p % HT);
        e.y    = 10'((p / HT) % VT);
        e.von  = ((p % HT) < HA) && (((p / HT) % VT) < VA);
        e.fs   = ((p % HT) == HT - 1) && (((p / HT) % VT) == VT - 1);
        e.bl   = (((p / FT) / BF) % 2) == 1;
        if (n == 1) begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.rgb = 12'hFFF;
        end else begin
            q     = p - 1;
            qx    = q % HT;
            qy    = (q / HT) % VT;
            e.hs  = !((qx >= HA + HF) && (qx < HA + HF + HS));
            e.vs  = !((qy >= VA + VF) && (qy < VA + VF + VS));
            e.rgb = (qx < HA && qy < VA) ? sel_color(qx, qy) : 12'h000;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (tick %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Issue expectations for nticks ticks, starting right after a reset release at a negedge.
    task automatic run_sb(input int nticks);
        sb_on = 1'b1;
        for (int n = 1; n <= nticks; n++) begin
            repeat (CLK_DIV) @(posedge clk);
            #1;
            chk("tick_missing", n - 1, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
            sb_q.push_back(model(n));
        end
        @(negedge clk);
        #1;
        chk("sb_drain", nticks, 32'(sb_q.size()), 32'd0);
        sb_on = 1'b0;
        sb_q.delete();
    endtask

    // Monitor: every presented pixel tick is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (pixel_tick) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_tick: got a pixel_tick, expected none");
                    end else begin
                        e = sb_q.pop_front();
                        chk("pixel_x",     e.idx, 32'(pixel_x),     32'(e.x));
                        chk("pixel_y",     e.idx, 32'(pixel_y),     32'(e.y));
                        chk("video_on",    e.idx, 32'(video_on),    32'(e.von));
                        chk("frame_start", e.idx, 32'(frame_start), 32'(e.fs));
                        chk("hsync",       e.idx, 32'(hsync),       32'(e.hs));
                        chk("vsync",       e.idx, 32'(vsync),       32'(e.vs));
                        chk("rgb_out",     e.idx, 32'(rgb_out),     32'(e.rgb));
                        chk("blink",       e.idx, 32'(blink),       32'(e.bl));
                    end
                end else begin
                    chk("fs_off_tick", -1, 32'(frame_start), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  cnt;
        bit  seen;
        n_tests  = 0;
        n_fail   = 0;
        sb_on    = 1'b0;
        rst      = 1'b1;
        blink_en = 1'b1;

        // Reset held: outputs at reset values.
        repeat (3) @(negedge clk);
        chk("rst_tick",  0, 32'(pixel_tick),  32'd0);
        chk("rst_x",     0, 32'(pixel_x),     32'd0);
        chk("rst_y",     0, 32'(pixel_y),     32'd0);
        chk("rst_hsync", 0, 32'(hsync),       32'd1);
        chk("rst_vsync", 0, 32'(vsync),       32'd1);
        chk("rst_rgb",   0, 32'(rgb_out),     32'hFFF);
        chk("rst_blink", 0, 32'(blink),       32'd0);
        chk("rst_fs",    0, 32'(frame_start), 32'd0);
        chk("rst_von",   0, 32'(video_on),    32'd1);

        // Four full frames plus a few ticks: raster, sync, colour and first blink toggle.
        rst = 1'b0;
        run_sb(4 * FT + 5);

        // blink_en low forces blink low on the next clock.
        chk("blink_pre", 0, 32'(blink), 32'd1);
        @(negedge clk);
        blink_en = 1'b0;
        @(negedge clk);
        #1;
        chk("blink_forced", 0, 32'(blink), 32'd0);

        // After re-enable, a full BF frames pass before the first toggle.
        blink_en = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < (BF + 2) * FT * CLK_DIV; i++) begin
            @(negedge clk);
            if (blink) begin
                seen = 1'b1;
                break;
            end
            if (frame_start) cnt++;
        end
        chk("reen_toggle_seen",   0, 32'(seen), 32'd1);
        chk("reen_toggle_frames", 0, 32'(cnt),  32'(BF));

        // Next half-period is again BF frames.
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < (BF + 2) * FT * CLK_DIV; i++) begin
            @(negedge clk);
            if (!blink) begin
                seen = 1'b1;
                break;
            end
            if (frame_start) cnt++;
        end
        chk("half_period_seen",   0, 32'(seen), 32'd1);
        chk("half_period_frames", 0, 32'(cnt),  32'(BF));

        // Asynchronous reset in the middle of the active area.
        seen = 1'b0;
        for (int i = 0; i < 2 * FT * CLK_DIV; i++) begin
            @(negedge clk);
            if (pixel_x == 10'd5 && pixel_y == 10'd4) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_pos_reached", 0, 32'(seen), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_x",     0, 32'(pixel_x),     32'd0);
        chk("mid_rst_y",     0, 32'(pixel_y),     32'd0);
        chk("mid_rst_tick",  0, 32'(pixel_tick),  32'd0);
        chk("mid_rst_hsync", 0, 32'(hsync),       32'd1);
        chk("mid_rst_vsync", 0, 32'(vsync),       32'd1);
        chk("mid_rst_rgb",   0, 32'(rgb_out),     32'hFFF);
        chk("mid_rst_blink", 0, 32'(blink),       32'd0);
        chk("mid_rst_fs",    0, 32'(frame_start), 32'd0);

        // Raster restarts from (0,0) after release.
        @(negedge clk);
        rst = 1'b0;
        run_sb(FT + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
